pc_sequencer: RTL

Program-counter sequencer for the Galetron core: the consumer of the control unit's flow-control outputs (`jump`, `bzero`, `bnegative`, `HLT`, `mainAddress`, `enable`). It holds the PC and the registered zero/negative flags, resolves jumps and conditional branches, and runs a small state machine for halt and for the blocking `in` instruction. It stalls the datapath while waiting for user input or after `hlt`.

---
 rtl/pc_sequencer_if.sv | 43 ++++
 rtl/pc_sequencer.sv | 98 +++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Flow-control bundle between the Galetron control unit and the PC sequencer.
//
// master: control unit / datapath side (drives flow requests, ALU status and
//         user buttons, consumes pc/flags/stall/inCommit/halted).
// slave : pc_sequencer side.
//
// Handshake: the `in` instruction is a blocking request/acknowledge pair.
// inRequest holds the sequencer in WAIT_IN (stall=1). The user's inConfirm
// rising edge acts as the valid strobe. inCommit is the one-cycle accept
// pulse in that same cycle; the register file writes only when inCommit=1.
interface pc_sequencer_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  jump;
  logic                  bzero;
  logic                  bnegative;
  logic                  HLT;
  logic                  enable;
  logic [ADDR_WIDTH-1:0] mainAddress;
  logic                  aluZero;
  logic                  aluNegative;
  logic                  inRequest;
  logic                  inConfirm;
  logic                  resume;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  zeroFlag;
  logic                  negativeFlag;
  logic                  stall;
  logic                  inCommit;
  logic                  halted;

  modport master (
    output jump, bzero, bnegative, HLT, enable, mainAddress,
           aluZero, aluNegative, inRequest, inConfirm, resume,
    input  pc, zeroFlag, negativeFlag, stall, inCommit, halted
  );

  modport slave (
    input  jump, bzero, bnegative, HLT, enable, mainAddress,
           aluZero, aluNegative, inRequest, inConfirm, resume,
    output pc, zeroFlag, negativeFlag, stall, inCommit, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the Galetron core.
// Holds the PC and the registered zero/negative flags, resolves jumps and
// conditional branches, and stalls the datapath during a blocking `in`
// (WAIT_IN) or after `hlt` (HALT).
//
// Ports:
//   clock     - single clock, rising edge
//   reset     - synchronous, active-low
//   bus       - pc_sequencer_if.slave (flow requests in; pc/flags/status out)
//   dbg_state - current FSM state (0=RUN, 1=WAIT_IN, 2=HALT)
module pc_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int RESET_ADDR = 0
) (
  input  logic                clock,
  input  logic                reset,
  pc_sequencer_if.slave       bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_IN = 2'd1,
    HALT    = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  zero_q;
  logic                  neg_q;
  // Reset to 1 so a button held through reset does not look like a press.
  logic                  confirm_prev;
  logic                  resume_prev;

  logic                  confirm_edge;
  logic                  resume_edge;
  logic                  take_branch;

  assign confirm_edge = bus.inConfirm & ~confirm_prev;
  assign resume_edge  = bus.resume & ~resume_prev;
  // Branches look at the flags latched by the previous op, not the live ALU.
  assign take_branch  = (bus.bzero & zero_q) | (bus.bnegative & neg_q);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= RUN;
      pc_q         <= ADDR_WIDTH'(RESET_ADDR);
      zero_q       <= 1'b0;
      neg_q        <= 1'b0;
      confirm_prev <= 1'b1;
      resume_prev  <= 1'b1;
    end else begin
      confirm_prev <= bus.inConfirm;
      resume_prev  <= bus.resume;
      case (state)
        RUN: begin
          if (bus.enable) begin
            zero_q <= bus.aluZero;
            neg_q  <= bus.aluNegative;
          end
          if (bus.HLT) begin
            state <= HALT;
          end else if (bus.inRequest) begin
            state <= WAIT_IN;
          end else if (bus.jump || take_branch) begin
            pc_q <= bus.mainAddress;
          end else begin
            pc_q <= pc_q + ADDR_WIDTH'(1);
          end
        end
        WAIT_IN: begin
          if (confirm_edge) begin
            pc_q  <= pc_q + ADDR_WIDTH'(1);
            state <= RUN;
          end
        end
        HALT: begin
          // resume_prev tracks the button during HALT, so only a fresh press
          // after entry produces resume_edge.
          if (resume_edge) begin
            pc_q  <= pc_q + ADDR_WIDTH'(1);
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.pc           = pc_q;
  assign bus.zeroFlag     = zero_q;
  assign bus.negativeFlag = neg_q;
  assign bus.stall        = (state != RUN);
  assign bus.halted       = (state == HALT);
  assign bus.inCommit     = (state == WAIT_IN) & confirm_edge;
  assign dbg_state        = state;

endmodule
